// File: rtl/gtech_event_qual_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gtech_event_qual_counter: synchronised A rising edge gated by NOT B,     |
// | emitted as a pulse and counted with sticky threshold/overflow flags.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gtech_event_qual_counter #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CP,
   input  logic             RST,
   input  logic             A,
   input  logic             B,
   input  logic             CLR,
   input  logic [WIDTH-1:0] THRESH,
   output logic             PULSE,
   output logic [WIDTH-1:0] COUNT,
   output logic             HIT,
   output logic             OVF
);

   localparam logic [WIDTH-1:0] C_MAX  = '1;
   localparam logic [WIDTH-1:0] C_ZERO = '0;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   a_d_q;
   logic                   pulse_q;
   logic [WIDTH-1:0]       count_q, count_d;
   logic                   hit_q, hit_d;
   logic                   ovf_q, ovf_d;
   logic                   w_a_s;
   logic                   w_rise;
   logic                   w_qual;
   logic [WIDTH-1:0]       w_count_inc;

   assign w_a_s       = sync_q[SYNC_STAGES-1];
   assign w_rise      = w_a_s & ~a_d_q;
   assign w_qual      = w_rise & ~B;
   assign w_count_inc = count_q + 1'b1;

   // Synchroniser and edge detector reset high so an A already high at
   // reset release is not mistaken for a fresh rising edge.
   always_ff @(posedge CP) begin
      if (RST) begin
         sync_q <= '1;
         a_d_q  <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], A};
         a_d_q  <= w_a_s;
      end
   end

   always_comb begin
      count_d = count_q;
      hit_d   = hit_q;
      ovf_d   = ovf_q;
      if (CLR) begin
         count_d = C_ZERO;
         hit_d   = 1'b0;
         ovf_d   = 1'b0;
      end else if (w_qual) begin
         // Saturation is tested before the increment so the count never wraps.
         if (count_q != C_MAX) begin
            count_d = w_count_inc;
            if ((THRESH != C_ZERO) && (w_count_inc == THRESH)) begin
               hit_d = 1'b1;
            end
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CP) begin
      if (RST) begin
         pulse_q <= 1'b0;
         count_q <= C_ZERO;
         hit_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         pulse_q <= w_qual;
         count_q <= count_d;
         hit_q   <= hit_d;
         ovf_q   <= ovf_d;
      end
   end

   assign PULSE = pulse_q;
   assign COUNT = count_q;
   assign HIT   = hit_q;
   assign OVF   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_gtech_event_qual_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gtech_event_qual_counter: directed scoreboard bench for the qualified |
// | event counter (WIDTH=8, SYNC_STAGES=2).                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_gtech_event_qual_counter;

   localparam int WIDTH = 8;
   localparam int MAXV  = (1 << WIDTH) - 1;

   typedef struct {
      int               due;
      logic             pulse;
      logic [WIDTH-1:0] count;
      logic             hit;
      logic             ovf;
   } exp_t;

   logic             CP = 1'b0;
   logic             RST = 1'b1;
   logic             A = 1'b1;
   logic             B = 1'b0;
   logic             CLR = 1'b0;
   logic [WIDTH-1:0] THRESH = '0;
   logic             PULSE;
   logic [WIDTH-1:0] COUNT;
   logic             HIT;
   logic             OVF;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   int   m_count = 0;
   logic m_hit = 1'b0;
   logic m_ovf = 1'b0;

   gtech_event_qual_counter #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
      .CP(CP), .RST(RST), .A(A), .B(B), .CLR(CLR), .THRESH(THRESH),
      .PULSE(PULSE), .COUNT(COUNT), .HIT(HIT), .OVF(OVF)
   );

   always #5 CP = ~CP;
   always @(posedge CP) cyc <= cyc + 1;

   // Scoreboard consumer: compare each expectation in the cycle it falls due.
   always @(negedge CP) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.due < cyc) begin
            checks++;
            errors++;
            $error("FAIL late_expect cyc=%0d observed=missed required_due=%0d", cyc, e.due);
         end else begin
            checks++;
            assert (PULSE === e.pulse) else begin
               errors++;
               $error("FAIL pulse cyc=%0d observed=%b required=%b", cyc, PULSE, e.pulse);
            end
            checks++;
            assert (COUNT === e.count) else begin
               errors++;
               $error("FAIL count cyc=%0d observed=%0d required=%0d", cyc, COUNT, e.count);
            end
            checks++;
            assert (HIT === e.hit) else begin
               errors++;
               $error("FAIL hit cyc=%0d observed=%b required=%b", cyc, HIT, e.hit);
            end
            checks++;
            assert (OVF === e.ovf) else begin
               errors++;
               $error("FAIL ovf cyc=%0d observed=%b required=%b", cyc, OVF, e.ovf);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CP);
         #1;
      end
   endtask

   task automatic expect_at(input int due, input logic p);
      exp_t e;
      e.due   = due;
      e.pulse = p;
      e.count = m_count[WIDTH-1:0];
      e.hit   = m_hit;
      e.ovf   = m_ovf;
      sb.push_back(e);
   endtask

   // One A pulse, 3 cycles high then 3 low; B may inhibit the edge and CLR
   // may coincide with the cycle the edge is qualified.
   task automatic send_event(input logic inh, input logic clr_same);
      int n;
      n = cyc;
      A = 1'b1;
      B = inh;
      if (clr_same) begin
         m_count = 0;
         m_hit   = 1'b0;
         m_ovf   = 1'b0;
      end else if (!inh) begin
         if (m_count != MAXV) begin
            m_count = m_count + 1;
            if (THRESH != 0 && m_count == int'(THRESH)) m_hit = 1'b1;
         end else begin
            m_ovf = 1'b1;
         end
      end
      expect_at(n + 3, !inh);
      expect_at(n + 4, 1'b0);
      step(2);
      if (clr_same) CLR = 1'b1;
      step(1);
      CLR = 1'b0;
      A   = 1'b0;
      B   = 1'b0;
      step(3);
   endtask

   task automatic do_clr();
      CLR     = 1'b1;
      m_count = 0;
      m_hit   = 1'b0;
      m_ovf   = 1'b0;
      expect_at(cyc + 1, 1'b0);
      step(1);
      CLR = 1'b0;
   endtask

   initial begin
      // Reset with A held high, then keep A high for 20 cycles after release.
      step(1);
      expect_at(cyc, 1'b0);
      step(2);
      RST = 1'b0;
      for (int i = 1; i <= 20; i++) expect_at(cyc + i, 1'b0);
      step(20);
      A = 1'b0;
      step(4);
      expect_at(cyc, 1'b0);
      step(1);

      // Five clean events.
      THRESH = 8'd0;
      for (int i = 0; i < 5; i++) send_event(1'b0, 1'b0);
      expect_at(cyc + 1, 1'b0);
      step(2);
      do_clr();

      // B inhibits edges 2 and 4.
      for (int i = 1; i <= 5; i++) send_event((i == 2) || (i == 4), 1'b0);
      do_clr();

      // Threshold 3 with four events, then clear.
      THRESH = 8'd3;
      for (int i = 0; i < 4; i++) send_event(1'b0, 1'b0);
      do_clr();

      // Lowering THRESH onto the existing count must not set HIT.
      THRESH = 8'd5;
      send_event(1'b0, 1'b0);
      THRESH = 8'd1;
      step(3);
      expect_at(cyc + 1, 1'b0);
      step(2);
      do_clr();

      // Saturation and overflow with 257 events.
      THRESH = 8'd0;
      for (int i = 0; i < 257; i++) send_event(1'b0, 1'b0);
      // CLR coinciding with a qualified edge: pulse still fires, count cleared.
      send_event(1'b0, 1'b1);
      send_event(1'b0, 1'b0);
      do_clr();

      // Reset mid-sequence at COUNT=7 with HIT set.
      THRESH = 8'd5;
      for (int i = 0; i < 7; i++) send_event(1'b0, 1'b0);
      RST     = 1'b1;
      CLR     = 1'b1;
      m_count = 0;
      m_hit   = 1'b0;
      m_ovf   = 1'b0;
      expect_at(cyc + 1, 1'b0);
      step(1);
      RST = 1'b0;
      CLR = 1'b0;
      for (int i = 1; i <= 10; i++) expect_at(cyc + i, 1'b0);
      step(10);
      send_event(1'b0, 1'b0);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL drain observed=%0d pending required=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
